// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, FSM encoding and helpers for the fetch stage
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction-memory req/ready port
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, addr, input rdata, ready);
    modport slave  (input req, addr, output rdata, ready);
endinterface

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, flush-to-bubble and hold
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc_d,
    input  logic [31:0] instr_d,
    output logic [31:0] pc_q,
    output logic [31:0] instr_q,
    output logic        valid_q
);

    // Flush leaves PC alone: ID ignores it when valid_q is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= 1'b1;
        end else if (flush) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: fetch PC, imem handshake FSM, redirect/stall handling
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic               PCsrc,
    input  logic               JUMP,
    input  logic [31:0]        NewPC,
    if_stage_if.master         imem,
    output logic [31:0]        PC,
    output logic [31:0]        INSTR,
    output logic               IF_valid
);

    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic [31:0]  redir_pc;
    logic [31:0]  buffer;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        load;
    logic        flush;
    logic [31:0] load_instr;

    // A stalled branch has not left ID, so its redirect is not yet real.
    assign redirect = (PCsrc | JUMP) & ~Stall;
    assign target   = align_word(NewPC);
    assign pc_plus4 = fetch_pc + 32'd4;

    assign imem.req  = rst_n & (state != ST_HOLD);
    assign imem.addr = fetch_pc;

    always_comb begin
        load       = 1'b0;
        load_instr = imem.rdata;
        case (state)
            ST_FETCH: load = imem.ready & ~redirect & ~Stall;
            ST_HOLD: begin
                load       = ~redirect & ~Stall;
                load_instr = buffer;
            end
            default: load = 1'b0;
        endcase
        // Anything not loading while ID advances becomes a bubble, redirects included.
        flush = ~Stall & ~load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            fetch_pc <= align_word(RESET_PC);
            redir_pc <= align_word(RESET_PC);
            buffer   <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem.ready) begin
                        if (redirect) begin
                            fetch_pc <= target;
                        end else if (Stall) begin
                            buffer <= imem.rdata;
                            state  <= ST_HOLD;
                        end else begin
                            fetch_pc <= pc_plus4;
                        end
                    end else if (redirect) begin
                        redir_pc <= target;
                        state    <= ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        state    <= ST_FETCH;
                    end else if (!Stall) begin
                        fetch_pc <= pc_plus4;
                        state    <= ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    // Outstanding request must complete before the new address goes out.
                    if (imem.ready) begin
                        fetch_pc <= redirect ? target : redir_pc;
                        state    <= ST_FETCH;
                    end else if (redirect) begin
                        redir_pc <= target;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .flush   (flush),
        .pc_d    (pc_plus4),
        .instr_d (load_instr),
        .pc_q    (PC),
        .instr_q (INSTR),
        .valid_q (IF_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, PCsrc, JUMP;
    logic [31:0] NewPC;
    logic        mem_ready;
    logic        ovr_en;
    logic [31:0] ovr_data;
    logic        zero_b = 1'b0;
    logic [31:0] zero32_b = 32'h0;

    logic [31:0] PC_a, INSTR_a, PC_b, INSTR_b;
    logic        valid_a, valid_b;

    int compared   = 0;
    int mismatched = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    always #5 clk = ~clk;

    if_stage_if bus_a();
    if_stage_if bus_b();

    assign bus_a.rdata = ovr_en ? ovr_data : (32'h1000_0000 | bus_a.addr);
    assign bus_a.ready = mem_ready;
    assign bus_b.rdata = 32'h1000_0000 | bus_b.addr;
    assign bus_b.ready = 1'b1;

    if_stage dut_a (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .PCsrc(PCsrc), .JUMP(JUMP), .NewPC(NewPC),
        .imem(bus_a.master), .PC(PC_a), .INSTR(INSTR_a), .IF_valid(valid_a)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_n), .Stall(zero_b), .PCsrc(zero_b), .JUMP(zero_b), .NewPC(zero32_b),
        .imem(bus_b.master), .PC(PC_b), .INSTR(INSTR_b), .IF_valid(valid_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ID consumes IF/ID whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (rst_n && valid_a && !Stall) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard: unexpected pc=%h instr=%h, nothing expected", PC_a, INSTR_a);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", PC_a, e[63:32]);
                check("sb_instr", INSTR_a, e[31:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; Stall = 1'b0; PCsrc = 1'b0; JUMP = 1'b0; NewPC = '0;
        mem_ready = 1'b1; ovr_en = 1'b0; ovr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   32'(bus_a.req), 32'h0);
        check("rst_addr",  bus_a.addr, 32'h0);
        check("rst_pc",    PC_a, 32'h0);
        check("rst_instr", INSTR_a, 32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_addr_b", bus_b.addr, 32'hFFFF_FFFC);
        check("rst_req_b", 32'(bus_b.req), 32'h0);
        rst_n = 1'b1;
        #1;
        // p0: zero-wait streaming
        check("t1_addr", bus_a.addr, 32'h0);
        check("t1_req", 32'(bus_a.req), 32'h1);
        check("t6_addr0", bus_b.addr, 32'hFFFF_FFFC);
        push(32'h4, 32'h1000_0000);
        for (int i = 1; i < 4; i++) begin
            step();
            check("t1_addr", bus_a.addr, 32'(4 * i));
            push(32'(4 * i + 4), 32'h1000_0000 | 32'(4 * i));
            if (i == 1) begin
                check("t6_addr1", bus_b.addr, 32'h0);
                check("t6_pc_wrap", PC_b, 32'h0);
                check("t6_instr", INSTR_b, 32'hFFFF_FFFC);
                check("t6_valid", 32'(valid_b), 32'h1);
            end
        end
        step(); // p4: branch at fetch 0x10
        check("t3_addr", bus_a.addr, 32'h10);
        PCsrc = 1'b1; NewPC = 32'h0000_0042;
        step(); // p5
        PCsrc = 1'b0;
        check("t3_bubble_valid", 32'(valid_a), 32'h0);
        check("t3_bubble_instr", INSTR_a, 32'h0);
        check("t3_target", bus_a.addr, 32'h40);
        push(32'h44, 32'h1000_0040);
        step(); // p6: stall with returned word
        check("t2_addr", bus_a.addr, 32'h44);
        Stall = 1'b1; ovr_en = 1'b1; ovr_data = 32'h8C01_0004;
        step(); // p7
        ovr_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t2_req_low", 32'(bus_a.req), 32'h0);
            check("t2_instr_held", INSTR_a, 32'h1000_0040);
            check("t2_pc_held", PC_a, 32'h44);
            if (i == 0) step(); // p8
        end
        step(); // p9
        Stall = 1'b0;
        check("t2_hold_req", 32'(bus_a.req), 32'h0);
        push(32'h48, 32'h8C01_0004);
        step(); // p10
        check("t2_next_addr", bus_a.addr, 32'h48);
        push(32'h4C, 32'h1000_0048);
        step(); // p11: jump while memory is slow
        check("t4_addr", bus_a.addr, 32'h4C);
        mem_ready = 1'b0; JUMP = 1'b1; NewPC = 32'h0000_0100;
        step(); // p12
        JUMP = 1'b0;
        check("t4_drain_req", 32'(bus_a.req), 32'h1);
        check("t4_drain_addr", bus_a.addr, 32'h4C);
        check("t4_drain_valid", 32'(valid_a), 32'h0);
        step(); // p13: second redirect while draining
        check("t4_addr_stable", bus_a.addr, 32'h4C);
        PCsrc = 1'b1; NewPC = 32'h0000_0200;
        step(); // p14
        PCsrc = 1'b0; mem_ready = 1'b1;
        check("t4_addr_stable2", bus_a.addr, 32'h4C);
        step(); // p15
        check("t4_latest_wins", bus_a.addr, 32'h200);
        check("t4_valid", 32'(valid_a), 32'h0);
        push(32'h204, 32'h1000_0200);
        step(); // p16: branch masked by stall
        check("t5_addr", bus_a.addr, 32'h204);
        Stall = 1'b1; PCsrc = 1'b1; NewPC = 32'h0000_0300;
        step(); // p17
        Stall = 1'b0;
        check("t5_held_valid", 32'(valid_a), 32'h1);
        check("t5_held_pc", PC_a, 32'h204);
        check("t5_held_instr", INSTR_a, 32'h1000_0200);
        check("t5_hold_req", 32'(bus_a.req), 32'h0);
        step(); // p18
        PCsrc = 1'b0;
        check("t5_target", bus_a.addr, 32'h300);
        check("t5_bubble", 32'(valid_a), 32'h0);
        push(32'h304, 32'h1000_0300);
        step(); // p19
        mem_ready = 1'b0;
        check("t6_pending_addr", bus_a.addr, 32'h304);
        step(); // p20: reset mid-request
        check("t6_wait_bubble", 32'(valid_a), 32'h0);
        check("t6_wait_req", 32'(bus_a.req), 32'h1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(bus_a.req), 32'h0);
        check("t6_rst_addr", bus_a.addr, 32'h0);
        check("t6_rst_addr_b", bus_b.addr, 32'hFFFF_FFFC);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        check("t6_restart_addr", bus_a.addr, 32'h0);
        check("t6_restart_req", 32'(bus_a.req), 32'h1);
        push(32'h4, 32'h1000_0000);
        step();
        push(32'h8, 32'h1000_0004);
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
